// File: rtl/relu_quant_pipe.sv
// Multi-lane ReLU / leaky-ReLU activation with shift requantisation, saturation,
// selectable alignment delay and a saturation counter. Build option: RELU_QUANT_ROUND_EN.
module relu_quant_pipe #(
  parameter int unsigned CH         = 4,
  parameter int unsigned IN_W       = 32,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned SHIFT      = 10,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned MAX_DLY    = 3,
  parameter int unsigned DSEL_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*IN_W-1:0]    din,
  input  logic                  ivalid,
  input  logic                  mode,
  input  logic [DSEL_W-1:0]     dly_sel,
  input  logic                  cnt_clr,
  output logic                  ovalid,
  output logic [CH*OUT_W-1:0]   dout,
  output logic [15:0]           sat_cnt
);

  localparam int unsigned NSAT_W = $clog2(CH + 1);
  localparam int unsigned SEL_W  = DSEL_W + 1;

  typedef logic signed [IN_W-1:0] lane_t;
  typedef logic signed [IN_W:0]   wide_t;

  localparam wide_t Q_MAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam wide_t Q_MIN = ~Q_MAX;
`ifdef RELU_QUANT_ROUND_EN
  localparam wide_t RND   = (IN_W+1)'(1) << (SHIFT - 1);
`endif

  // Returns {clamped_flag, OUT_W-bit result} for one lane.
  function automatic logic [OUT_W:0] quant(input lane_t x);
    wide_t ext;
    wide_t q;
    ext = {x[IN_W-1], x};
`ifdef RELU_QUANT_ROUND_EN
    ext = ext + RND;
`endif
    q = ext >>> SHIFT;
    if (q > Q_MAX)      quant = {1'b1, Q_MAX[OUT_W-1:0]};
    else if (q < Q_MIN) quant = {1'b1, Q_MIN[OUT_W-1:0]};
    else                quant = {1'b0, q[OUT_W-1:0]};
  endfunction

  lane_t                 din_l [CH];
  lane_t                 act_d [CH];
  lane_t                 act_q [CH];
  logic                  v1_d, v1_q;
  logic [MAX_DLY-1:0]    dv_d, dv_q;
  lane_t                 dd_d [MAX_DLY][CH];
  lane_t                 dd_q [MAX_DLY][CH];
  logic [SEL_W-1:0]      sel_c;
  logic                  tap_v_c;
  lane_t                 tap_l_c [CH];
  logic [OUT_W:0]        qr_c [CH];
  logic [NSAT_W-1:0]     nsat_c;
  logic [16:0]           sat_sum_c;
  logic                  ovalid_d, ovalid_q;
  logic [CH*OUT_W-1:0]   dout_d, dout_q;
  logic [15:0]           sat_cnt_d, sat_cnt_q;

  // Stage 1: activation
  always_comb begin
    v1_d = ivalid;
    for (int k = 0; k < CH; k++) begin
      din_l[k] = din[k*IN_W +: IN_W];
      act_d[k] = din_l[k];
      if (din_l[k][IN_W-1]) begin
        if (mode) act_d[k] = din_l[k] >>> LEAK_SHIFT;
        else      act_d[k] = '0;
      end
    end
  end

  // Alignment chain and tap select; valid and data always share one tap
  always_comb begin
    dv_d[0] = v1_q;
    dd_d[0] = act_q;
    for (int j = 1; j < MAX_DLY; j++) begin
      dv_d[j] = dv_q[j-1];
      dd_d[j] = dd_q[j-1];
    end
    sel_c   = (SEL_W'(dly_sel) > SEL_W'(MAX_DLY)) ? SEL_W'(MAX_DLY) : SEL_W'(dly_sel);
    tap_v_c = v1_q;
    tap_l_c = act_q;
    for (int j = 1; j <= MAX_DLY; j++) begin
      if (sel_c == SEL_W'(j)) begin
        tap_v_c = dv_q[j-1];
        tap_l_c = dd_q[j-1];
      end
    end
  end

  // Output stage: requantise, saturate, count clamped lanes
  always_comb begin
    dout_d   = '0;
    nsat_c   = '0;
    ovalid_d = tap_v_c;
    for (int k = 0; k < CH; k++) begin
      qr_c[k] = quant(tap_l_c[k]);
      dout_d[k*OUT_W +: OUT_W] = qr_c[k][OUT_W-1:0];
      nsat_c = nsat_c + NSAT_W'(qr_c[k][OUT_W]);
    end
    sat_sum_c = {1'b0, sat_cnt_q} + 17'(nsat_c);
    sat_cnt_d = sat_cnt_q;
    if (cnt_clr)      sat_cnt_d = '0;
    else if (tap_v_c) sat_cnt_d = sat_sum_c[16] ? 16'hFFFF : sat_sum_c[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      dv_q      <= '0;
      ovalid_q  <= 1'b0;
      dout_q    <= '0;
      sat_cnt_q <= '0;
    end else begin
      v1_q      <= v1_d;
      dv_q      <= dv_d;
      ovalid_q  <= ovalid_d;
      dout_q    <= dout_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  // Data-only registers; qualified by the reset valid chain
  always_ff @(posedge clk) begin
    act_q <= act_d;
    dd_q  <= dd_d;
  end

  assign ovalid  = ovalid_q;
  assign dout    = dout_q;
  assign sat_cnt = sat_cnt_q;

endmodule
